// File: rtl/coolgirl_pkg.sv
// Shared types and width helpers for the console-variant probe.
// Holds the FSM encodings, the registered-output bundle and the sizing functions.
package coolgirl_pkg;

   typedef enum logic [2:0] {
      ST_HOLD     = 3'd0,
      ST_SETTLE   = 3'd1,
      ST_SAMPLE   = 3'd2,
      ST_DONE_STD = 3'd3,
      ST_DONE_NEW = 3'd4,
      ST_TIMEOUT  = 3'd5
   } probe_state_t;

   typedef struct packed {
      logic hold_active;
      logic new_dendy;
      logic detect_done;
      logic detect_timeout;
   } probe_out_t;

   localparam probe_out_t PROBE_OUT_RESET = '{hold_active: 1'b1, default: 1'b0};

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int timer_width(input int a, input int b, input int c);
      return $clog2(max3(a, b, c)) + 1;
   endfunction

   function automatic int count_width(input int quota);
      return (quota < 1) ? 1 : $clog2(quota + 1);
   endfunction

   function automatic probe_out_t decode_outputs(input probe_state_t s);
      probe_out_t o;
      o.hold_active    = (s == ST_HOLD);
      o.new_dendy      = (s == ST_DONE_NEW);
      o.detect_done    = (s == ST_DONE_STD) || (s == ST_DONE_NEW) || (s == ST_TIMEOUT);
      o.detect_timeout = (s == ST_TIMEOUT);
      return o;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Single-bit synchroniser of configurable depth for PPU pins sampled on M2.
// Resets high so an inactive /RD is seen until real data has propagated.
module sync_chain #(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [DEPTH-1:0] chain_q;

   // NOTE: flops use non-blocking assignments so every stage samples the pre-edge value of its neighbour.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain_q <= '1;
      end else begin
         chain_q[0] <= d_i;
         for (int i = 1; i < DEPTH; i++) begin
            chain_q[i] <= chain_q[i-1];
         end
      end
   end

   assign q_o = chain_q[DEPTH-1];

endmodule

// File: rtl/console_probe.sv
// Power-on console-variant detector: grounds CIRAM during a hold window, then
// samples PPU A13 against the console /A13 pin to tell standard consoles from new famiclones.
module console_probe
   import coolgirl_pkg::*;
#(
   parameter int INIT_CYCLES    = 15,
   parameter int SETTLE_CYCLES  = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int SAMPLES_LO     = 3,
   parameter int SAMPLES_HI     = 3,
   parameter int MISMATCH_MIN   = 1,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       m2,
   input  logic       rst_n,
   input  logic       ppu_rd_in,
   input  logic       ppu_a13,
   input  logic       ppu_not_a13,
   input  logic       rearm,
   output logic       hold_active,
   output logic       new_dendy,
   output logic       detect_done,
   output logic       detect_timeout,
   output logic [2:0] probe_state
);

   localparam int TW = timer_width(INIT_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES);
   localparam int LW = count_width(SAMPLES_LO);
   localparam int HW = count_width(SAMPLES_HI);
   localparam int MW = count_width(MISMATCH_MIN);

   localparam logic [TW-1:0] INIT_LAST    = TW'(INIT_CYCLES - 1);
   localparam logic [TW-1:0] SETTLE_LAST  = (SETTLE_CYCLES == 0) ? '0 : TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0] LO_QUOTA     = LW'(SAMPLES_LO);
   localparam logic [HW-1:0] HI_QUOTA     = HW'(SAMPLES_HI);
   localparam logic [MW-1:0] MIS_QUOTA    = MW'(MISMATCH_MIN);

   probe_state_t  state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [LW-1:0] lo_q, lo_d, lo_nxt;
   logic [HW-1:0] hi_q, hi_d, hi_nxt;
   logic [MW-1:0] mis_q, mis_d, mis_nxt;
   probe_out_t    out_q, out_d;

   logic rd_s, a13_s, na13_s;
   logic qualify, mismatch, rearm_ok, timer_run;

   // All three pins share one depth so they are compared from the same stage.
   sync_chain #(.DEPTH(SYNC_STAGES)) u_sync_rd (
      .clk(m2), .rst_n(rst_n), .d_i(ppu_rd_in), .q_o(rd_s)
   );
   sync_chain #(.DEPTH(SYNC_STAGES)) u_sync_a13 (
      .clk(m2), .rst_n(rst_n), .d_i(ppu_a13), .q_o(a13_s)
   );
   sync_chain #(.DEPTH(SYNC_STAGES)) u_sync_na13 (
      .clk(m2), .rst_n(rst_n), .d_i(ppu_not_a13), .q_o(na13_s)
   );

   // NOTE: every variable gets a default at the top of always_comb, so no path can infer a latch.
   always_comb begin
      qualify  = ~rd_s;
      mismatch = qualify && (a13_s == na13_s) && (lo_q != '0) && (hi_q != '0);

      lo_nxt = lo_q;
      if (qualify && !a13_s && (lo_q != LO_QUOTA)) lo_nxt = lo_q + LW'(1);

      hi_nxt = hi_q;
      if (qualify && a13_s && (hi_q != HI_QUOTA)) hi_nxt = hi_q + HW'(1);

      mis_nxt = mis_q;
      if (mismatch && (mis_q != MIS_QUOTA)) mis_nxt = mis_q + MW'(1);

      rearm_ok  = rearm && (state_q != ST_HOLD) && (state_q != ST_SETTLE);
      timer_run = (state_q == ST_HOLD) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HOLD: begin
            if (timer_q == INIT_LAST) state_d = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (timer_q == SETTLE_LAST) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            // Exit checks look at the post-sample counts so the verdict lands one edge after the sample.
            if (mis_nxt == MIS_QUOTA)                         state_d = ST_DONE_NEW;
            else if ((lo_nxt == LO_QUOTA) && (hi_nxt == HI_QUOTA)) state_d = ST_DONE_STD;
            else if (timer_q == TIMEOUT_LAST)                 state_d = ST_TIMEOUT;
         end
         default: state_d = state_q;
      endcase
      if (rearm_ok) state_d = ST_SAMPLE;

      if ((state_d != state_q) || rearm_ok) timer_d = '0;
      else if (timer_run)                   timer_d = timer_q + TW'(1);
      else                                  timer_d = timer_q;

      lo_d  = lo_q;
      hi_d  = hi_q;
      mis_d = mis_q;
      if (rearm_ok) begin
         lo_d  = '0;
         hi_d  = '0;
         mis_d = '0;
      end else if (state_q == ST_SAMPLE) begin
         lo_d  = lo_nxt;
         hi_d  = hi_nxt;
         mis_d = mis_nxt;
      end
   end

   always_comb begin
      out_d = decode_outputs(state_d);
   end

   // NOTE: the async reset forces hold_active high immediately, matching a console power cycle.
   always_ff @(posedge m2 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_HOLD;
         timer_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         mis_q   <= '0;
         out_q   <= PROBE_OUT_RESET;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         mis_q   <= mis_d;
         out_q   <= out_d;
      end
   end

   assign hold_active    = out_q.hold_active;
   assign new_dendy      = out_q.new_dendy;
   assign detect_done    = out_q.detect_done;
   assign detect_timeout = out_q.detect_timeout;
   assign probe_state    = state_q;

endmodule

// File: tb/tb_console_probe.sv
// Self-checking bench for console_probe: a default instance plus one with MISMATCH_MIN=2,
// driven from a shared stimulus table and a few hand-written timing sequences.
module tb_console_probe;
   import coolgirl_pkg::*;

   logic m2 = 1'b0;
   logic rst_n = 1'b0;
   logic ppu_rd_in = 1'b1;
   logic ppu_a13 = 1'b0;
   logic ppu_not_a13 = 1'b1;
   logic rearm = 1'b0;

   logic       hold1, nd1, done1, to1;
   logic [2:0] st1;
   logic       hold2, nd2, done2, to2;
   logic [2:0] st2;

   int n_checks = 0;
   int n_fail = 0;

   always #5 m2 = ~m2;

   console_probe dut (
      .m2(m2), .rst_n(rst_n), .ppu_rd_in(ppu_rd_in), .ppu_a13(ppu_a13),
      .ppu_not_a13(ppu_not_a13), .rearm(rearm),
      .hold_active(hold1), .new_dendy(nd1), .detect_done(done1),
      .detect_timeout(to1), .probe_state(st1)
   );

   console_probe #(.MISMATCH_MIN(2)) dut_m2 (
      .m2(m2), .rst_n(rst_n), .ppu_rd_in(ppu_rd_in), .ppu_a13(ppu_a13),
      .ppu_not_a13(ppu_not_a13), .rearm(rearm),
      .hold_active(hold2), .new_dendy(nd2), .detect_done(done2),
      .detect_timeout(to2), .probe_state(st2)
   );

   typedef struct {
      string        name;
      int           n;
      logic [7:0]   a13;
      logic [7:0]   mis;
      probe_state_t exp1;
      probe_state_t exp2;
   } vec_t;

   typedef struct {
      string        name;
      probe_state_t exp1;
      probe_state_t exp2;
   } exp_t;

   vec_t vecs[5];
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic edges(input int n);
      repeat (n) @(negedge m2);
   endtask

   task automatic do_reset();
      @(negedge m2);
      rst_n = 1'b0;
      ppu_rd_in = 1'b1;
      ppu_a13 = 1'b0;
      ppu_not_a13 = 1'b1;
      rearm = 1'b0;
      edges(2);
      rst_n = 1'b1;
   endtask

   // One qualifying /RD sample; called right after a falling M2 edge.
   task automatic pulse(input logic a, input logic mis, input int idle);
      ppu_rd_in = 1'b0;
      ppu_a13 = a;
      ppu_not_a13 = mis ? a : ~a;
      edges(1);
      ppu_rd_in = 1'b1;
      ppu_not_a13 = ~ppu_a13;
      edges(idle);
   endtask

   // Starts right after reset release; ends with the probe in SAMPLE.
   task automatic check_hold_window(input string tag, input bit with_rearm);
      if (with_rearm) begin
         edges(3);
         rearm = 1'b1;
         edges(1);
         rearm = 1'b0;
         check({tag, " rearm ignored in HOLD"}, 32'(st1), 32'(ST_HOLD));
         edges(10);
      end else begin
         edges(14);
      end
      check({tag, " hold high at edge 14"}, 32'(hold1), 32'd1);
      check({tag, " state HOLD at edge 14"}, 32'(st1), 32'(ST_HOLD));
      edges(1);
      check({tag, " hold low at edge 15"}, 32'(hold1), 32'd0);
      check({tag, " state SETTLE at edge 15"}, 32'(st1), 32'(ST_SETTLE));
      edges(3);
      check({tag, " still SETTLE at edge 18"}, 32'(st1), 32'(ST_SETTLE));
      edges(1);
      check({tag, " SAMPLE at edge 19"}, 32'(st1), 32'(ST_SAMPLE));
   endtask

   initial begin
      exp_t e;

      vecs[0] = '{"normal",      6, 8'b0010_1010, 8'b0000_0000, ST_DONE_STD, ST_DONE_STD};
      vecs[1] = '{"famiclone",   6, 8'b0010_1010, 8'b0000_1000, ST_DONE_NEW, ST_DONE_STD};
      vecs[2] = '{"early_glitch",6, 8'b0011_1000, 8'b0000_1011, ST_DONE_STD, ST_DONE_STD};
      vecs[3] = '{"double_mis",  4, 8'b0000_1010, 8'b0000_1100, ST_DONE_NEW, ST_DONE_NEW};
      vecs[4] = '{"saturate_lo", 8, 8'b1110_0000, 8'b0000_0000, ST_DONE_STD, ST_DONE_STD};

      // Reset values, hold window with an ignored rearm, then timeout.
      edges(1);
      check("reset hold_active", 32'(hold1), 32'd1);
      check("reset state", 32'(st1), 32'(ST_HOLD));
      check("reset outputs", 32'({nd1, done1, to1}), 32'd0);
      do_reset();
      check_hold_window("boot", 1'b1);
      edges(4095);
      check("pre-timeout state", 32'(st1), 32'(ST_SAMPLE));
      edges(1);
      check("timeout state", 32'(st1), 32'(ST_TIMEOUT));
      check("timeout flags", 32'({nd1, done1, to1}), 32'b011);
      check("timeout flags m2", 32'({nd2, done2, to2}), 32'b011);

      // Table-driven verdicts through a scoreboard.
      for (int i = 0; i < 5; i++) begin
         int k;
         do_reset();
         edges(19);
         check({vecs[i].name, " in SAMPLE"}, 32'(st1), 32'(ST_SAMPLE));
         sb.push_back('{vecs[i].name, vecs[i].exp1, vecs[i].exp2});
         for (int j = 0; j < vecs[i].n; j++) begin
            pulse(vecs[i].a13[j], vecs[i].mis[j], 2);
         end
         k = 0;
         while (k < 60 && !(done1 && done2)) begin
            edges(1);
            k++;
         end
         e = sb.pop_front();
         check({e.name, " done"}, 32'({done1, done2}), 32'b11);
         check({e.name, " state"}, 32'(st1), 32'(e.exp1));
         check({e.name, " new_dendy"}, 32'(nd1), 32'(e.exp1 == ST_DONE_NEW));
         check({e.name, " state m2"}, 32'(st2), 32'(e.exp2));
         check({e.name, " new_dendy m2"}, 32'(nd2), 32'(e.exp2 == ST_DONE_NEW));
         check({e.name, " no timeout"}, 32'({to1, to2}), 32'd0);
      end

      // Verdict latency, then rearm out of DONE_NEW.
      do_reset();
      edges(19);
      pulse(1'b0, 1'b0, 2);
      pulse(1'b1, 1'b0, 2);
      pulse(1'b0, 1'b0, 2);
      pulse(1'b1, 1'b1, 0);
      edges(1);
      check("latency edge 2 new_dendy", 32'(nd1), 32'd0);
      check("latency edge 2 state", 32'(st1), 32'(ST_SAMPLE));
      edges(1);
      check("latency edge 3 new_dendy", 32'(nd1), 32'd1);
      check("latency edge 3 done", 32'({st1, done1}), 32'({3'(ST_DONE_NEW), 1'b1}));
      rearm = 1'b1;
      edges(1);
      rearm = 1'b0;
      check("rearm state", 32'(st1), 32'(ST_SAMPLE));
      check("rearm flags", 32'({hold1, nd1, done1, to1}), 32'd0);
      pulse(1'b0, 1'b0, 2);
      pulse(1'b1, 1'b0, 2);
      edges(3);
      check("rearm cleared counters", 32'(st1), 32'(ST_SAMPLE));

      // Asynchronous reset between edges while sampling.
      @(posedge m2);
      #2 rst_n = 1'b0;
      #1;
      check("async reset hold", 32'(hold1), 32'd1);
      check("async reset state", 32'(st1), 32'(ST_HOLD));
      check("async reset flags", 32'({nd1, done1, to1}), 32'd0);
      edges(2);
      rst_n = 1'b1;
      check_hold_window("after async reset", 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/console_probe.md
# console_probe

Power-on console-variant detector for the cartridge CPLD, clocked by M2. It replaces the fixed power-on hold and first-mismatch PPU A13 detector with a parametrised, synchronised probe. The probe has:
- a configurable ground-hold window;
- per-phase sample quotas;
- a mismatch threshold;
- a timeout;
- software re-arm.

Its outputs drive the CIRAM /CE and /A13 grounding logic and the `new_dendy` select in the top level.

## Interface
Parameters:
- `INIT_CYCLES`, 15: M2 cycles that `hold_active` stays high after reset release. Range 1..65535.
- `SETTLE_CYCLES`, 4: M2 cycles after hold release before sampling starts. Range 0..255.
- `SYNC_STAGES`, 2: synchroniser depth on the PPU inputs. Range 1..3.
- `SAMPLES_LO`, 3: qualifying samples required with A13=0. Range ≥1.
- `SAMPLES_HI`, 3: qualifying samples required with A13=1. Range ≥1.
- `MISMATCH_MIN`, 1: mismatching samples that declare a new famiclone. Range 1..255.
- `TIMEOUT_CYCLES`, 4096: M2 cycles allowed in SAMPLE before giving up. Range ≥1.

Ports:
- `m2`, input, 1: CPU M2 clock. All logic is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `ppu_rd_in`, input, 1: PPU /RD, asynchronous to `m2`.
- `ppu_a13`, input, 1: PPU A13.
- `ppu_not_a13`, input, 1: console /A13 pin, read back.
- `rearm`, input, 1: one-cycle pulse that restarts detection.
- `hold_active`, output, 1: high means ground CIRAM /CE and /A13.
- `new_dendy`, output, 1: new-famiclone verdict.
- `detect_done`, output, 1: a verdict (normal or timeout) is valid.
- `detect_timeout`, output, 1: the verdict came from timeout.
- `probe_state`, output, 3: current FSM state encoding.

## Operation
- The FSM has six states.
  - HOLD=0: `hold_active`=1 and the timer counts.
  - SETTLE=1: hold is released and the timer counts.
  - SAMPLE=2: counters are active and the timer counts.
  - DONE_STD=3: verdict `new_dendy`=0.
  - DONE_NEW=4: verdict `new_dendy`=1.
  - TIMEOUT=5: verdict `new_dendy`=0 and `detect_timeout`=1.
- Reset values:
  - state = HOLD, timer = 0, all counters = 0;
  - `hold_active`=1;
  - `new_dendy`=0, `detect_done`=0, `detect_timeout`=0.
- HOLD → SETTLE when timer = `INIT_CYCLES`−1. The timer clears on every transition.
- SETTLE → SAMPLE when timer = `SETTLE_CYCLES`−1. If `SETTLE_CYCLES`=0, HOLD goes directly to SAMPLE.
- SAMPLE:
  - A sample qualifies when the synchronised /RD = 0.
  - A qualifying sample with A13=0 increments `lo_cnt`. One with A13=1 increments `hi_cnt`. Both counters saturate at their quota.
  - A sample mismatches when A13 == `ppu_not_a13`, i.e. the /A13 pin is not the complement of A13.
  - A mismatch increments `mis_cnt`, but only while `lo_cnt`≥1 and `hi_cnt`≥1. This preserves the "both phases seen" gating; early-boot glitches do not count.
- Exits from SAMPLE, in priority order:
  - `mis_cnt` reaches `MISMATCH_MIN` → DONE_NEW.
  - Otherwise, `lo_cnt`=`SAMPLES_LO` and `hi_cnt`=`SAMPLES_HI` → DONE_STD.
  - Otherwise, timer = `TIMEOUT_CYCLES`−1 → TIMEOUT.
- Verdict states are absorbing until `rearm` or reset.
- `rearm` behaviour:
  - In SAMPLE or any verdict state: go to SAMPLE, clear counters, timer, `new_dendy`, `detect_done` and `detect_timeout` on the next edge. `rearm` never re-enters HOLD.
  - In HOLD or SETTLE: ignored.
- If `rearm` and a SAMPLE exit condition occur in the same cycle, `rearm` wins.
- Counter widths are `$clog2(quota+1)`. The timer width is `$clog2` of the maximum of the three cycle parameters, plus 1.

## Timing
- All outputs are registered. `hold_active` falls on the edge that leaves HOLD, exactly `INIT_CYCLES` rising edges after `rst_n` deasserts.
- PPU input latency: `SYNC_STAGES` edges from pin to sample.
  - /RD, A13 and /A13 pass through identical-depth chains.
  - All three are compared from the same stage.
- Verdict latency: `new_dendy` and `detect_done` assert on the edge following the sample that satisfies the exit condition, i.e. `SYNC_STAGES`+1 edges after the pin event.
- `rst_n` low mid-operation:
  - Forces the reset values immediately, independent of `m2`.
  - `hold_active` re-asserts, because a reset implies a console power cycle.
- A missing or stopped `m2` holds state; there is no internal oscillator.

## Structure
- Shared package `coolgirl_pkg`:
  - the `probe_state_t` enum (3-bit encodings above);
  - a `clog2`-based width helper for the timer.
- One natural sub-module: `sync_chain` (parametrised depth, 1-bit, reset to 1).
  - Instantiated three times.
  - Resetting to 1 guarantees no false qualifying /RD sample after reset.

## Test plan
- Defaults, hold window: release `rst_n`, no PPU activity → `hold_active`=1 for 15 edges then 0. SAMPLE reached 4 edges later. TIMEOUT after 4096 more edges with `detect_timeout`=1 and `new_dendy`=0.
- Normal console: drive /RD pulses alternating A13=0/1 with `ppu_not_a13`=~A13 → DONE_STD after 3+3 samples, `new_dendy`=0, `detect_done`=1.
- Famiclone: the same stimulus, but the 4th qualifying sample has `ppu_not_a13`=A13 → DONE_NEW and `new_dendy`=1 at sample edge + 1. With `MISMATCH_MIN`=2, a single mismatch must yield DONE_STD.
- Early glitch: a mismatch while `hi_cnt`=0 must not count → DONE_STD.
- Re-arm: `rearm` pulse in DONE_NEW → `probe_state`=2 and `new_dendy`=0 next edge, `hold_active` stays 0. A `rearm` pulse in HOLD has no effect.
- Async reset mid-SAMPLE: `rst_n` low between edges → `hold_active`=1 and `probe_state`=0 immediately, and the full 15-cycle hold repeats after release.
